// File: rtl/led_code_rx_pkg.sv
// Shared definitions for the pulse-width-coded LED line receiver.
// Holds frame FSM encoding, pulse classes, error codes, symbol geometry
// and the nominal tick widths also used by the LED transmitter.
package led_code_rx_pkg;

    localparam int unsigned SYM_BITS     = 5;
    localparam int unsigned SYMS_PER_MSG = 4;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned CNT_W        = 6;
    localparam int unsigned BIT_CNT_W    = 3;
    localparam int unsigned ERR_W        = 2;

    // Nominal line timing in ticks, shared with the transmitter
    localparam int unsigned NOM_ZERO_TICKS = 7;
    localparam int unsigned NOM_ONE_TICKS  = 12;
    localparam int unsigned NOM_BIT_TICKS  = 20;
    localparam int unsigned NOM_SEP_TICKS  = 1;

    localparam logic [ERR_W-1:0] ERR_NONE       = 2'd0;
    localparam logic [ERR_W-1:0] ERR_SEP_IN_SYM = 2'd1;
    localparam logic [ERR_W-1:0] ERR_OVERLONG   = 2'd2;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT_SEP,
        ST_SEP
    } rx_state_t;

    typedef enum logic [1:0] {
        PC_SEP,
        PC_ZERO,
        PC_ONE,
        PC_LONG
    } pulse_class_t;

    // One completed high pulse, reported at its falling edge
    typedef struct packed {
        logic         valid;
        pulse_class_t cls;
    } pulse_evt_t;

    // Map a measured high width onto its protocol meaning
    function automatic pulse_class_t classify_width(
        input logic [CNT_W-1:0] w,
        input logic [CNT_W-1:0] zero_min,
        input logic [CNT_W-1:0] one_min,
        input logic [CNT_W-1:0] one_max
    );
        if (w < zero_min)      return PC_SEP;
        else if (w < one_min)  return PC_ZERO;
        else if (w <= one_max) return PC_ONE;
        else                   return PC_LONG;
    endfunction

endpackage

// File: rtl/led_pulse_meter.sv
// Line front end: synchronizes led_in, divides clk into protocol ticks,
// measures high and low widths in ticks and reports each finished high
// pulse as a classified event plus a once-per-gap timeout strobe.
//   clk, rst_n   : clock, async active-low reset
//   led_in       : raw asynchronous coded line
//   pulse_evt_c  : valid for one cycle at the synchronized falling edge
//   timeout_c    : one cycle when the low gap reaches GAP_TIMEOUT ticks
module led_pulse_meter
    import led_code_rx_pkg::*;
#(
    parameter int unsigned CLK_PER_TICK = 1,
    parameter int unsigned ZERO_MIN     = 4,
    parameter int unsigned ONE_MIN      = 10,
    parameter int unsigned ONE_MAX      = 15,
    parameter int unsigned GAP_TIMEOUT  = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       led_in,
    output pulse_evt_t pulse_evt_c,
    output logic       timeout_c
);

    localparam int unsigned PRE_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       sync_q;
    logic             line_d_q;
    logic [PRE_W-1:0] pre_q;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] gap_q;
    logic             to_seen_q;

    logic line_c;
    logic rise_c;
    logic fall_c;
    logic tick_c;

    assign line_c = sync_q[1];
    assign rise_c = line_c & ~line_d_q;
    assign fall_c = ~line_c & line_d_q;
    assign tick_c = (pre_q == PRE_W'(CLK_PER_TICK - 1));

    // Two-flop synchronizer plus edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            line_d_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], led_in};
            line_d_q <= line_c;
        end
    end

    // Free-running tick prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);
    end

    // High width; the rising-edge cycle already counts as high time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q <= '0;
        end else if (rise_c) begin
            width_q <= tick_c ? CNT_W'(1) : '0;
        end else if (line_c && tick_c && (width_q != CNT_MAX)) begin
            width_q <= width_q + CNT_W'(1);
        end
    end

    // Low gap width, mirrored on the falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else if (fall_c) begin
            gap_q <= tick_c ? CNT_W'(1) : '0;
        end else if (!line_c && tick_c && (gap_q != CNT_MAX)) begin
            gap_q <= gap_q + CNT_W'(1);
        end
    end

    // Remembers that this gap already timed out (prescaler may dwell on the value)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         to_seen_q <= 1'b0;
        else if (fall_c)    to_seen_q <= 1'b0;
        else if (timeout_c) to_seen_q <= 1'b1;
    end

    // Steady-low requirement keeps a stale gap value from firing at a fall
    assign timeout_c = ~line_c & ~line_d_q & ~to_seen_q &
                       (gap_q == CNT_W'(GAP_TIMEOUT));

    // Sub-tick pulses (width 0) are dropped
    always_comb begin
        pulse_evt_c.valid = fall_c && (width_q != '0);
        pulse_evt_c.cls   = classify_width(width_q, CNT_W'(ZERO_MIN),
                                           CNT_W'(ONE_MIN), CNT_W'(ONE_MAX));
    end

endmodule

// File: rtl/led_code_rx.sv
// Pulse-width-coded LED line decoder. Assembles 5-bit symbols MSB first
// from classified pulses and reports four symbols per message.
//   clk, rst_n : clock, async active-low reset
//   led_in     : asynchronous coded line
//   sym_data   : last decoded symbol, bit 4 received first (held)
//   sym_valid  : one-cycle strobe for a new symbol
//   sym_idx    : position 0..3 of sym_data within its message
//   msg_done   : strobe with sym_valid on the last symbol of a message
//   err        : one-cycle protocol error strobe
//   err_code   : 1 separator in symbol, 2 overlong, 3 gap timeout (held)
module led_code_rx
    import led_code_rx_pkg::*;
#(
    parameter int unsigned CLK_PER_TICK = 1,
    parameter int unsigned ZERO_MIN     = 4,
    parameter int unsigned ONE_MIN      = 10,
    parameter int unsigned ONE_MAX      = 15,
    parameter int unsigned GAP_TIMEOUT  = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                led_in,
    output logic [SYM_BITS-1:0] sym_data,
    output logic                sym_valid,
    output logic [IDX_W-1:0]    sym_idx,
    output logic                msg_done,
    output logic                err,
    output logic [ERR_W-1:0]    err_code
);

    pulse_evt_t pulse_evt_c;
    logic       timeout_c;

    led_pulse_meter #(
        .CLK_PER_TICK (CLK_PER_TICK),
        .ZERO_MIN     (ZERO_MIN),
        .ONE_MIN      (ONE_MIN),
        .ONE_MAX      (ONE_MAX),
        .GAP_TIMEOUT  (GAP_TIMEOUT)
    ) u_meter (
        .clk         (clk),
        .rst_n       (rst_n),
        .led_in      (led_in),
        .pulse_evt_c (pulse_evt_c),
        .timeout_c   (timeout_c)
    );

    rx_state_t              state_q,    state_d;
    logic [SYM_BITS-1:0]    shreg_q,    shreg_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [IDX_W-1:0]       next_idx_q, next_idx_d;
    logic [SYM_BITS-1:0]    sym_data_d;
    logic                   sym_valid_d;
    logic [IDX_W-1:0]       sym_idx_d;
    logic                   msg_done_d;
    logic                   err_d;
    logic [ERR_W-1:0]       err_code_d;

    logic                bit_val_c;
    logic [SYM_BITS-1:0] shifted_c;

    assign bit_val_c = (pulse_evt_c.cls == PC_ONE);
    assign shifted_c = {shreg_q[SYM_BITS-2:0], bit_val_c};

    // Frame state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            next_idx_q <= '0;
            sym_data   <= '0;
            sym_valid  <= 1'b0;
            sym_idx    <= '0;
            msg_done   <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            next_idx_q <= next_idx_d;
            sym_data   <= sym_data_d;
            sym_valid  <= sym_valid_d;
            sym_idx    <= sym_idx_d;
            msg_done   <= msg_done_d;
            err        <= err_d;
            err_code   <= err_code_d;
        end
    end

    // Frame FSM: next state, symbol assembly and error reporting
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        next_idx_d  = next_idx_q;
        sym_data_d  = sym_data;
        sym_valid_d = 1'b0;
        sym_idx_d   = sym_idx;
        msg_done_d  = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code;

        if (pulse_evt_c.valid) begin
            unique case (pulse_evt_c.cls)
                PC_LONG: begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERLONG;
                    shreg_d    = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_IDLE;
                end
                PC_SEP: begin
                    unique case (state_q)
                        ST_DATA: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_SEP_IN_SYM;
                            shreg_d    = '0;
                            bit_cnt_d  = '0;
                            state_d    = ST_IDLE;
                        end
                        ST_WAIT_SEP, ST_SEP: state_d = ST_SEP;
                        default:             state_d = ST_IDLE;
                    endcase
                end
                PC_ZERO, PC_ONE: begin
                    if (state_q == ST_DATA) begin
                        shreg_d = shifted_c;
                        if (bit_cnt_q == BIT_CNT_W'(SYM_BITS - 1)) begin
                            sym_valid_d = 1'b1;
                            sym_data_d  = shifted_c;
                            sym_idx_d   = next_idx_q;
                            msg_done_d  = (next_idx_q == IDX_W'(SYMS_PER_MSG - 1));
                            next_idx_d  = next_idx_q + IDX_W'(1);
                            bit_cnt_d   = '0;
                            state_d     = ST_WAIT_SEP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end else begin
                        // A bit straight after a symbol counts as a missing separator
                        shreg_d   = {{(SYM_BITS-1){1'b0}}, bit_val_c};
                        bit_cnt_d = BIT_CNT_W'(1);
                        state_d   = ST_DATA;
                    end
                end
                default: state_d = state_q;
            endcase
        end else if (timeout_c && ((state_q != ST_IDLE) || (next_idx_q != '0))) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            shreg_d    = '0;
            bit_cnt_d  = '0;
            next_idx_d = '0;
            sym_idx_d  = '0;
            state_d    = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_led_code_rx.sv
// Scoreboard bench for led_code_rx: stimulus pushes expected symbol/error
// events, a negedge monitor pops and compares each event the DUT emits.
module tb_led_code_rx;
    import led_code_rx_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       led_in;
    logic [4:0] sym_data;
    logic       sym_valid;
    logic [1:0] sym_idx;
    logic       msg_done;
    logic       err;
    logic [1:0] err_code;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_err;
        logic [4:0] data;
        logic [1:0] idx;
        bit         done;
        logic [1:0] code;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    led_code_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .led_in    (led_in),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .sym_idx   (sym_idx),
        .msg_done  (msg_done),
        .err       (err),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, pending=%0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    // Monitor: every output event must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && (sym_valid || err)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got valid=%0b err=%0b data=%b idx=%0d code=%0d, expected none",
                         sym_valid, err, sym_data, sym_idx, err_code);
            end else begin
                cur = exp_q.pop_front();
                if (cur.is_err) begin
                    if (!(err && !sym_valid && !msg_done && err_code == cur.code && sym_idx == cur.idx)) begin
                        bad++;
                        $display("FAIL err_event: got err=%0b valid=%0b code=%0d idx=%0d, expected err=1 valid=0 code=%0d idx=%0d",
                                 err, sym_valid, err_code, sym_idx, cur.code, cur.idx);
                    end
                end else begin
                    if (!(sym_valid && !err && sym_data == cur.data && sym_idx == cur.idx && msg_done == cur.done)) begin
                        bad++;
                        $display("FAIL sym_event: got valid=%0b err=%0b data=%b idx=%0d done=%0b, expected data=%b idx=%0d done=%0b",
                                 sym_valid, err, sym_data, sym_idx, msg_done, cur.data, cur.idx, cur.done);
                    end
                end
            end
        end
    end

    task automatic check(input bit ok, input string name, input int act, input int expv);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic check_cleared(input string tag);
        check(sym_data == 5'd0, {tag, "_sym_data"}, int'(sym_data), 0);
        check(sym_valid == 1'b0, {tag, "_sym_valid"}, int'(sym_valid), 0);
        check(sym_idx == 2'd0, {tag, "_sym_idx"}, int'(sym_idx), 0);
        check(msg_done == 1'b0, {tag, "_msg_done"}, int'(msg_done), 0);
        check(err == 1'b0, {tag, "_err"}, int'(err), 0);
        check(err_code == 2'd0, {tag, "_err_code"}, int'(err_code), 0);
    endtask

    // Hold the line at lvl for n sampling edges
    task automatic drive(input logic lvl, input int n);
        led_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int hi;
        hi = b ? int'(NOM_ONE_TICKS) : int'(NOM_ZERO_TICKS);
        drive(1'b1, hi);
        drive(1'b0, int'(NOM_BIT_TICKS) - hi);
    endtask

    task automatic expect_sym(input logic [4:0] d, input logic [1:0] idx, input bit done);
        exp_t e;
        e.is_err = 1'b0; e.data = d; e.idx = idx; e.done = done; e.code = 2'd0;
        exp_q.push_back(e);
    endtask

    task automatic expect_err(input logic [1:0] code, input logic [1:0] idx);
        exp_t e;
        e.is_err = 1'b1; e.data = 5'd0; e.idx = idx; e.done = 1'b0; e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic send_sym(input logic [4:0] s, input logic [1:0] idx, input bit done);
        expect_sym(s, idx, done);
        for (int i = 4; i >= 0; i--) send_bit(s[i]);
    endtask

    task automatic send_sep();
        repeat (5) begin
            drive(1'b1, int'(NOM_SEP_TICKS));
            drive(1'b0, 1);
        end
        drive(1'b0, 4);
    endtask

    task automatic apply_reset();
        led_in = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 3);
    endtask

    initial begin
        rst_n  = 1'b0;
        led_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;
        drive(1'b0, 5);

        // Single symbol with separator
        send_sym(5'b10110, 2'd0, 1'b0);
        send_sep();

        // Full message, then the next message restarts at index 0
        apply_reset();
        send_sym(5'b00001, 2'd0, 1'b0); send_sep();
        send_sym(5'b11111, 2'd1, 1'b0); send_sep();
        send_sym(5'b01010, 2'd2, 1'b0); send_sep();
        send_sym(5'b10000, 2'd3, 1'b1); send_sep();
        send_sym(5'b10110, 2'd0, 1'b0); send_sep();

        // Separator inside a symbol; index is kept
        apply_reset();
        send_sym(5'b10101, 2'd0, 1'b0); send_sep();
        expect_err(ERR_SEP_IN_SYM, 2'd0);
        send_bit(1'b1);
        send_bit(1'b0);
        drive(1'b1, 1);
        drive(1'b0, 5);
        send_sym(5'b01100, 2'd1, 1'b0); send_sep();

        // Overlong pulse, then gap timeout after three bits
        apply_reset();
        expect_err(ERR_OVERLONG, 2'd0);
        drive(1'b1, 20);
        drive(1'b0, 10);
        send_sym(5'b11100, 2'd0, 1'b0); send_sep();
        send_bit(1'b1);
        send_bit(1'b0);
        expect_err(ERR_TIMEOUT, 2'd0);
        drive(1'b1, 12);
        drive(1'b0, 45);
        send_sym(5'b00011, 2'd0, 1'b0); send_sep();

        // Width boundaries: 4,9 -> 0; 10,15 -> 1; 3 -> SEP; 16 -> overlong
        apply_reset();
        expect_sym(5'b00111, 2'd0, 1'b0);
        drive(1'b1, 4);  drive(1'b0, 10);
        drive(1'b1, 9);  drive(1'b0, 10);
        drive(1'b1, 10); drive(1'b0, 10);
        drive(1'b1, 15); drive(1'b0, 10);
        drive(1'b1, 10); drive(1'b0, 10);
        send_sep();
        expect_err(ERR_SEP_IN_SYM, 2'd0);
        drive(1'b1, 10); drive(1'b0, 10);
        drive(1'b1, 3);  drive(1'b0, 10);
        drive(1'b1, 3);  drive(1'b0, 10);
        expect_err(ERR_OVERLONG, 2'd0);
        drive(1'b1, 16); drive(1'b0, 10);

        // Missing separator between symbols, then reset during bit 3
        apply_reset();
        send_sym(5'b11001, 2'd0, 1'b0);
        send_sym(5'b00101, 2'd1, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        drive(1'b1, 5);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("midreset");
        led_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 5);
        send_sym(5'b10011, 2'd0, 1'b0); send_sep();

        drive(1'b0, 10);
        check(exp_q.size() == 0, "pending_expectations", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_code_rx.md
# led_code_rx

Receiver/decoder for the pulse-width-coded LED line driven by the LED transmitter. Samples the line, classifies each high pulse as data-0, data-1 or separator, assembles 5-bit symbols MSB first, and reports four symbols per message to the passcode checker downstream. Sits between the board input pin (or a loopback of the transmitter's LED output) and the passcode compare logic.

## Interface
- CLK_PER_TICK, default 1: clk cycles per protocol tick; internal prescaler emits a one-cycle tick strobe.
- ZERO_MIN, default 4: minimum high width (ticks) classed as data-0; widths 1..ZERO_MIN-1 are separator pulses.
- ONE_MIN, default 10: minimum high width classed as data-1; ZERO_MIN..ONE_MIN-1 is data-0.
- ONE_MAX, default 15: maximum legal data-1 width; wider is an overlong error.
- GAP_TIMEOUT, default 40: low ticks after which a partial frame is abandoned.
- clk  in  1  system clock; one clock; all state on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- led_in  in  1  asynchronous coded line (nominal: high 7 ticks = 0, high 12 ticks = 1, bit period 20 ticks, separator = burst of 1-tick pulses).
- sym_data  out  5  last decoded symbol, bit 4 = first bit received; held until next sym_valid.
- sym_valid  out  1  one-cycle strobe, new symbol on sym_data.
- sym_idx  out  2  position (0..3) of the symbol on sym_data within its message.
- msg_done  out  1  one-cycle strobe coincident with sym_valid when sym_idx = 3.
- err  out  1  one-cycle strobe on protocol error.
- err_code  out  2  1 = separator pulse inside a symbol, 2 = overlong pulse, 3 = gap timeout; held until next err.

## Operation
- led_in passes a 2-flop synchronizer; edges detected on synchronized value.
- Width counter (6 bits, saturating at 63) counts tick strobes while line high; gap counter (6 bits, saturating) counts ticks while low. Both clear on the respective rising/falling edge.
- Classification at each falling edge: w < ZERO_MIN → SEP; ZERO_MIN ≤ w < ONE_MIN → bit 0; ONE_MIN ≤ w ≤ ONE_MAX → bit 1; w > ONE_MAX → overlong. w = 0 (pulse shorter than one tick) is ignored.
- States: IDLE (no bits held), DATA (1..4 bits held), WAIT_SEP (5 bits delivered, separator not yet seen), SEP (≥1 separator pulse seen).
- IDLE/SEP + bit → shift in, bit_cnt = 1, DATA. IDLE + SEP pulse → stay IDLE.
- DATA + bit → shift in; on fifth bit assert sym_valid with sym_idx, go WAIT_SEP; sym_idx increments mod 4 after delivery.
- DATA + SEP pulse → err code 1, discard partial symbol, IDLE; sym_idx unchanged.
- WAIT_SEP + SEP pulse → SEP. WAIT_SEP + bit → treated as missing separator: accept bit as first bit of next symbol (no error).
- Any state + overlong → err code 2, discard partial, IDLE.
- Gap counter reaching GAP_TIMEOUT while state ≠ IDLE or sym_idx ≠ 0 → err code 3, discard partial, sym_idx = 0, IDLE. Fires once per gap.
- Error and sym_valid cannot coincide (exclusive classification outcomes).

## Timing
- Reset values: sym_data 0, sym_valid 0, sym_idx 0, msg_done 0, err 0, err_code 0; state IDLE; counters 0; synchronizer flops 0.
- sym_valid/err rise on the 1st clk after the synchronized falling edge is detected (3 clk after the pin falls, ignoring metastability); width ambiguity ±1 tick from synchronization.
- Timeout err asserts on the clk after the gap counter reaches GAP_TIMEOUT.
- rst_n low mid-frame: all outputs and state clear immediately; first pulse after release is decoded as a fresh first bit.
- Line held high: width counter saturates, overlong reported at eventual falling edge only.

## Structure
- Shared package: state encoding enum, err_code constants (ERR_SEP_IN_SYM, ERR_OVERLONG, ERR_TIMEOUT), SYM_BITS = 5, SYMS_PER_MSG = 4, nominal tick widths shared with the transmitter.
- One sub-module natural: led_pulse_meter (synchronizer, prescaler, width/gap counters, emits classified pulse event + timeout strobe); the top holds the frame FSM.

## Test plan
- Symbol 10110 (widths 12,7,12,12,7, 20-tick period) then 9-toggle separator → one sym_valid, sym_data = 5'b10110, sym_idx = 0, no err.
- Four symbols 00001,11111,01010,10000 each with separator → sym_idx 0..3, msg_done with the 4th, next message restarts at sym_idx 0.
- Two bits then a 1-tick pulse → err, err_code 1, no sym_valid; following clean symbol decodes with sym_idx unchanged.
- 20-tick high pulse → err, err_code 2; 45-tick low after 3 bits → err, err_code 3, sym_idx 0.
- Boundary widths 3/4/9/10/15/16 → SEP/0/0/1/1/overlong respectively; rst_n pulsed low during bit 3 → outputs 0, next full symbol decodes correctly.
